uart_transmitter: RTL

Serial transmit side of the UART link. Accepts a 7-bit character on a one-cycle start strobe, latches it, and shifts out a 10-bit frame on `tx`: start bit, 7 data bits LSB first, parity bit, stop bit. Each bit lasts a programmable number of clock cycles. The frame format matches what the receive path captures and checks: 7 data bits, 1 parity bit and 1 stop bit.

---
 rtl/uart_pkg.sv | 22 ++
 rtl/uart_baud_tick.sv | 37 +++
 rtl/uart_transmitter.sv | 124 ++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Constants and types shared by the UART transmit and receive paths.
package uart_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
      ST_PARITY = 3'd3,
      ST_STOP   = 3'd4
   } uart_state_e;

   localparam int   UART_DATA_BITS  = 7;
   localparam int   UART_FRAME_BITS = 10;
   localparam logic UART_IDLE_LEVEL = 1'b1;

   // Even parity when odd == 0; odd parity when odd == 1.
   function automatic logic calc_parity(input logic [UART_DATA_BITS-1:0] d,
                                        input logic                      odd);
      return (^d) ^ odd;
   endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 while not cleared and flags the
// last cycle of each bit with a one-cycle tick.
module uart_baud_tick #(
   parameter int CLKS_PER_BIT = 5208
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   output logic tick
);

   localparam int                CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CNT_W-1:0] LAST  = CNT_W'(CLKS_PER_BIT - 1);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clear || (cnt_q == LAST)) begin
         cnt_d = '0;
      end else begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign tick = !clear && (cnt_q == LAST);

endmodule

// File: rtl/uart_transmitter.sv
// UART transmitter: start bit, 7 data bits LSB first, parity, stop bit.
// All outputs are registered; state is exposed on state_dbg for checkers.
module uart_transmitter
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = 5208,
   parameter bit PARITY_ODD   = 1'b0
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   input  logic [6:0] data_in,
   output logic       tx,
   output logic       busy,
   output logic       done,
   output logic [2:0] state_dbg
);

   uart_state_e                 state_q, state_d;
   logic [UART_DATA_BITS-1:0]   shift_q, shift_d;
   logic                        parity_q, parity_d;
   logic [2:0]                  bit_cnt_q, bit_cnt_d;
   logic                        tx_q, tx_d;
   logic                        busy_q, busy_d;
   logic                        done_q, done_d;
   logic                        bit_end;

   // The counter is held cleared in IDLE, so it starts at 0 on the acceptance edge.
   uart_baud_tick #(
      .CLKS_PER_BIT(CLKS_PER_BIT)
   ) u_baud_tick (
      .clk  (clk),
      .reset(reset),
      .clear(state_q == ST_IDLE),
      .tick (bit_end)
   );

   always_comb begin
      state_d   = state_q;
      shift_d   = shift_q;
      parity_d  = parity_q;
      bit_cnt_d = bit_cnt_q;
      tx_d      = tx_q;
      busy_d    = busy_q;
      done_d    = 1'b0;
      case (state_q)
         ST_IDLE: begin
            tx_d   = UART_IDLE_LEVEL;
            busy_d = 1'b0;
            if (start) begin
               shift_d   = data_in;
               parity_d  = calc_parity(data_in, PARITY_ODD);
               bit_cnt_d = 3'd0;
               state_d   = ST_START;
               tx_d      = 1'b0;
               busy_d    = 1'b1;
            end
         end
         ST_START: begin
            if (bit_end) begin
               state_d = ST_DATA;
               tx_d    = shift_q[0];
            end
         end
         ST_DATA: begin
            if (bit_end) begin
               shift_d   = shift_q >> 1;
               bit_cnt_d = bit_cnt_q + 3'd1;
               if (bit_cnt_q == 3'(UART_DATA_BITS - 1)) begin
                  state_d = ST_PARITY;
                  tx_d    = parity_q;
               end else begin
                  tx_d = shift_q[1];
               end
            end
         end
         ST_PARITY: begin
            if (bit_end) begin
               state_d = ST_STOP;
               tx_d    = 1'b1;
            end
         end
         ST_STOP: begin
            if (bit_end) begin
               state_d = ST_IDLE;
               tx_d    = UART_IDLE_LEVEL;
               busy_d  = 1'b0;
               done_d  = 1'b1;
            end
         end
         default: begin
            state_d = ST_IDLE;
            tx_d    = UART_IDLE_LEVEL;
            busy_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= ST_IDLE;
         shift_q   <= '0;
         parity_q  <= 1'b0;
         bit_cnt_q <= 3'd0;
         tx_q      <= UART_IDLE_LEVEL;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         shift_q   <= shift_d;
         parity_q  <= parity_d;
         bit_cnt_q <= bit_cnt_d;
         tx_q      <= tx_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
      end
   end

   assign tx        = tx_q;
   assign busy      = busy_q;
   assign done      = done_q;
   assign state_dbg = state_q;

endmodule
